// File: rtl/fg_pkg.sv
// Shared definitions for the function-generator output stage.
//   fg_out_state_t : output-stage FSM states (IDLE, RAMP_UP, RUN, RAMP_DOWN)
//   sat_limit      : clip a sign-extended value to the signed range of a given width
package fg_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } fg_out_state_t;

  // Working width for sat_limit; callers sign-extend into it and slice the result.
  localparam int SAT_CALC_W = 32;

  // Clips value to [-2^(width-1), 2^(width-1)-1]. clipped is set only when the value
  // lies strictly outside that range, so an exact MIN or MAX is not a clip.
  function automatic logic signed [SAT_CALC_W-1:0] sat_limit(
    input  logic signed [SAT_CALC_W-1:0] value,
    input  int                           width,
    output logic                         clipped
  );
    logic signed [SAT_CALC_W-1:0] hi;
    logic signed [SAT_CALC_W-1:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    clipped = 1'b0;
    sat_limit = value;
    if (value > hi) begin
      sat_limit = hi;
      clipped   = 1'b1;
    end else if (value < lo) begin
      sat_limit = lo;
      clipped   = 1'b1;
    end
  endfunction

endpackage

// File: rtl/fg_slew_step.sv
// One slew-limited step from current toward target (combinational).
//   current  : present output sample (signed)
//   target   : desired sample (signed)
//   max_step : largest allowed |target - current| per step; 0 jumps straight to target
//   next_val : sample after this step
//   done     : next_val has reached target
module fg_slew_step
  import fg_pkg::*;
#(
  parameter int BITWIDTH = 16
) (
  input  logic signed [BITWIDTH-1:0] current,
  input  logic signed [BITWIDTH-1:0] target,
  input  logic        [BITWIDTH-1:0] max_step,
  output logic signed [BITWIDTH-1:0] next_val,
  output logic                       done
);

  // One extra bit keeps the difference of two full-range samples exact.
  logic signed [BITWIDTH:0] diff;
  logic signed [BITWIDTH:0] step_pos;
  logic signed [BITWIDTH:0] step_neg;
  logic signed [BITWIDTH:0] step;
  logic                     step_unused;

  always_comb begin
    diff     = {target[BITWIDTH-1], target} - {current[BITWIDTH-1], current};
    step_pos = {1'b0, max_step};
    step_neg = -step_pos;
    if (max_step == '0) begin
      step = diff;
    end else if (diff > step_pos) begin
      step = step_pos;
    end else if (diff < step_neg) begin
      step = step_neg;
    end else begin
      step = diff;
    end
    // The clamped step never overshoots target, so the sum stays in range and
    // modular BITWIDTH-bit addition is exact.
    next_val = current + step[BITWIDTH-1:0];
    done     = (next_val == target);
  end

  assign step_unused = step[BITWIDTH];

endmodule

// File: rtl/fg_output_slew_limiter.sv
// Registered output stage of the function generator.
// Stage 1 selects a source, adds the offset and saturates; stage 2 slew-limits toward
// the target (the stage-1 sample while enabled, zero while ramping down / idle).
// Handshake: valid_i is a one-cycle sample strobe with no backpressure (no ready);
// every strobe produces exactly one valid_o pulse two clocks later.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   outputEnable_i    request output; low ramps to zero then idles
//   valid_i           sample strobe for select_i / offset_i / data_i
//   select_i          source index (out-of-range selects source 0)
//   offset_i          signed offset added to the selected source
//   data_i            DATA_COUNT packed signed sources of BITWIDTH+1 bits
//   maxStep_i         max |delta| per output sample, 0 disables slew limiting
//   satClear_i        synchronous clear of satCount_o
//   out_o, valid_o    limited sample and its one-cycle update pulse
//   active_o          high whenever the FSM is not IDLE
//   satCount_o        saturating count of clipped samples
//   state_o           FSM state (debug visibility)
module fg_output_slew_limiter
  import fg_pkg::*;
#(
  parameter  int BITWIDTH      = 16,
  parameter  int DATA_COUNT    = 3,
  parameter  int SAT_CNT_WIDTH = 8,
  localparam int SEL_W         = (DATA_COUNT > 1) ? $clog2(DATA_COUNT) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                outputEnable_i,
  input  logic                                valid_i,
  input  logic [SEL_W-1:0]                    select_i,
  input  logic [BITWIDTH-1:0]                 offset_i,
  input  logic [DATA_COUNT*(BITWIDTH+1)-1:0]  data_i,
  input  logic [BITWIDTH-1:0]                 maxStep_i,
  input  logic                                satClear_i,
  output logic signed [BITWIDTH-1:0]          out_o,
  output logic                                valid_o,
  output logic                                active_o,
  output logic [SAT_CNT_WIDTH-1:0]            satCount_o,
  output logic [1:0]                          state_o
);

  // ---------------- Stage 1: select, offset, saturate ----------------
  logic [BITWIDTH:0]              src_sel;
  logic signed [BITWIDTH+1:0]     sum;
  logic signed [SAT_CALC_W-1:0]   sum_ext;
  logic signed [SAT_CALC_W-1:0]   sat_ext;
  logic                           clip_c;
  logic                           sat_unused_bits;

  logic signed [BITWIDTH-1:0]     s1;
  logic                           clip1;
  logic                           v1;

  always_comb begin
    src_sel = data_i[BITWIDTH:0];
    for (int k = 1; k < DATA_COUNT; k++) begin
      if (int'(select_i) == k) begin
        src_sel = data_i[k*(BITWIDTH+1) +: (BITWIDTH+1)];
      end
    end
    // Two guard bits: a full-range source plus a full-range offset cannot overflow.
    sum     = {src_sel[BITWIDTH], src_sel} + {{2{offset_i[BITWIDTH-1]}}, offset_i};
    sum_ext = {{(SAT_CALC_W-BITWIDTH-2){sum[BITWIDTH+1]}}, sum};
    sat_ext = sat_limit(sum_ext, BITWIDTH, clip_c);
  end

  assign sat_unused_bits = ^sat_ext[SAT_CALC_W-1:BITWIDTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1    <= 1'b0;
      s1    <= '0;
      clip1 <= 1'b0;
    end else begin
      v1 <= valid_i;
      if (valid_i) begin
        s1    <= sat_ext[BITWIDTH-1:0];
        clip1 <= clip_c;
      end
    end
  end

  // ---------------- Stage 2: slew limit and FSM ----------------
  fg_out_state_t               state_q;
  fg_out_state_t               state_d;
  logic signed [BITWIDTH-1:0]  target;
  logic signed [BITWIDTH-1:0]  step_next;
  logic                        step_done;

  // Ramping down and idling both steer the output to zero.
  assign target = (state_q == IDLE || state_q == RAMP_DOWN) ? '0 : s1;

  fg_slew_step #(
    .BITWIDTH (BITWIDTH)
  ) u_slew_step (
    .current  (out_o),
    .target   (target),
    .max_step (maxStep_i),
    .next_val (step_next),
    .done     (step_done)
  );

  // Enable transitions are checked first so they win over a coincident ramp completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (outputEnable_i) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (!outputEnable_i)       state_d = RAMP_DOWN;
        else if (v1 && step_done)  state_d = RUN;
      end
      RUN: begin
        if (!outputEnable_i) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (outputEnable_i)        state_d = RAMP_UP;
        else if (v1 && step_done)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      out_o   <= '0;
      valid_o <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_o <= v1;
      if (v1) begin
        out_o <= step_next;
      end
    end
  end

  // ---------------- Clip counter ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      satCount_o <= '0;
    end else if (satClear_i) begin
      satCount_o <= '0;
    end else if (v1 && clip1 && state_q != IDLE && !(&satCount_o)) begin
      satCount_o <= satCount_o + 1'b1;
    end
  end

  assign active_o = (state_q != IDLE);
  assign state_o  = state_q;

endmodule

// File: tb/tb_fg_output_slew_limiter.sv
module tb_fg_output_slew_limiter;

  localparam int BW  = 16;
  localparam int DC  = 3;
  localparam int SCW = 8;
  localparam int S_IDLE = 0;
  localparam int S_UP   = 1;
  localparam int S_RUN  = 2;
  localparam int S_DOWN = 3;
  localparam int VMAX = 32767;
  localparam int VMIN = -32768;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                      outputEnable_i = 1'b0;
  logic                      valid_i = 1'b0;
  logic [1:0]                select_i = '0;
  logic [BW-1:0]             offset_i = '0;
  logic [DC*(BW+1)-1:0]      data_i = '0;
  logic [BW-1:0]             maxStep_i = '0;
  logic                      satClear_i = 1'b0;
  logic signed [BW-1:0]      out_o;
  logic                      valid_o;
  logic                      active_o;
  logic [SCW-1:0]            satCount_o;
  logic [1:0]                state_o;

  fg_output_slew_limiter #(
    .BITWIDTH      (BW),
    .DATA_COUNT    (DC),
    .SAT_CNT_WIDTH (SCW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .outputEnable_i (outputEnable_i),
    .valid_i        (valid_i),
    .select_i       (select_i),
    .offset_i       (offset_i),
    .data_i         (data_i),
    .maxStep_i      (maxStep_i),
    .satClear_i     (satClear_i),
    .out_o          (out_o),
    .valid_o        (valid_o),
    .active_o       (active_o),
    .satCount_o     (satCount_o),
    .state_o        (state_o)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [BW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Behaviour in plain integer arithmetic: the sample taken on a strobe becomes
  // visible two clocks later, moved toward its target by at most maxStep.
  int src_v[DC];
  int m_out, m_s1, m_state, m_cnt;
  bit m_v1, m_clip1, m_valid;

  task automatic model_reset();
    m_out = 0; m_s1 = 0; m_state = S_IDLE; m_cnt = 0;
    m_v1 = 0; m_clip1 = 0; m_valid = 0;
  endtask

  task automatic model_step();
    int tgt, nout, ms, ns, ncnt, idx, off, sum;
    if (rst) begin
      model_reset();
      return;
    end
    tgt  = (m_state == S_UP || m_state == S_RUN) ? m_s1 : 0;
    ms   = int'(maxStep_i);
    nout = m_out;
    if (m_v1) begin
      if (ms == 0 || (tgt - m_out <= ms && m_out - tgt <= ms)) nout = tgt;
      else if (tgt > m_out) nout = m_out + ms;
      else nout = m_out - ms;
    end
    ns = m_state;
    case (m_state)
      S_IDLE: if (outputEnable_i) ns = S_UP;
      S_UP:   if (!outputEnable_i) ns = S_DOWN; else if (m_v1 && nout == tgt) ns = S_RUN;
      S_RUN:  if (!outputEnable_i) ns = S_DOWN;
      default: if (outputEnable_i) ns = S_UP; else if (m_v1 && nout == 0) ns = S_IDLE;
    endcase
    ncnt = m_cnt;
    if (satClear_i) ncnt = 0;
    else if (m_v1 && m_clip1 && m_state != S_IDLE && m_cnt < 255) ncnt = m_cnt + 1;
    m_valid = m_v1;
    m_out   = nout;
    m_state = ns;
    m_cnt   = ncnt;
    if (valid_i) begin
      idx = (int'(select_i) < DC) ? int'(select_i) : 0;
      off = $signed(offset_i);
      sum = src_v[idx] + off;
      m_clip1 = (sum > VMAX) || (sum < VMIN);
      m_s1 = (sum > VMAX) ? VMAX : (sum < VMIN) ? VMIN : sum;
    end
    m_v1 = valid_i;
  endtask

  // ---------------- driver tasks ----------------
  task automatic pack();
    for (int k = 0; k < DC; k++) data_i[k*(BW+1) +: (BW+1)] = 17'(src_v[k]);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input int sel, input int off);
    select_i = 2'(sel);
    offset_i = 16'(off);
    valid_i  = 1'b1;
    cycle();
    valid_i  = 1'b0;
    cycle();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    n_vec++; if (out_o !== 16'sd0) begin n_err++; $display("FAIL reset_out: got %0d want 0", out_o); end
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_vec++; if (active_o !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b want 0", active_o); end
    n_vec++; if (satCount_o !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", satCount_o); end
    n_vec++; if (state_o !== 2'(S_IDLE)) begin n_err++; $display("FAIL reset_state: got %0d want %0d", state_o, S_IDLE); end
  endtask

  task automatic test_clip_max();
    outputEnable_i = 1'b1;
    maxStep_i = '0;
    cycle();
    src_v[0] = 0; src_v[1] = 32767; src_v[2] = 0;
    pack();
    send_sample(1, 100);
    n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL clipmax_valid: got %b want 1", valid_o); end
    n_vec++; if (out_o !== 16'sd32767) begin n_err++; $display("FAIL clipmax_out: got %0d want 32767", out_o); end
    n_vec++; if (satCount_o !== 8'd1) begin n_err++; $display("FAIL clipmax_count: got %0d want 1", satCount_o); end
  endtask

  task automatic test_clip_min();
    src_v[0] = -32768;
    pack();
    send_sample(0, -1);
    n_vec++; if (out_o !== -16'sd32768) begin n_err++; $display("FAIL clipmin_out: got %0d want -32768", out_o); end
    n_vec++; if (satCount_o !== 8'd2) begin n_err++; $display("FAIL clipmin_count: got %0d want 2", satCount_o); end
    send_sample(0, 0);
    n_vec++; if (out_o !== -16'sd32768) begin n_err++; $display("FAIL exactmin_out: got %0d want -32768", out_o); end
    n_vec++; if (satCount_o !== 8'd2) begin n_err++; $display("FAIL exactmin_count: got %0d want 2", satCount_o); end
  endtask

  task automatic test_ramp_up();
    int exp_seq[5] = '{1000, 2000, 3000, 4000, 5000};
    int k = 0;
    pulse_reset();
    outputEnable_i = 1'b1;
    maxStep_i = 16'd1000;
    cycle();
    src_v[0] = 5000;
    pack();
    select_i = 2'd0;
    offset_i = '0;
    for (int i = 0; i < 10; i++) begin
      valid_i = (i < 5);
      cycle();
      n_vec++; if (active_o !== 1'b1) begin n_err++; $display("FAIL rampup_active cyc %0d: got %b want 1", i, active_o); end
      if (valid_o === 1'b1 && k < 5) begin
        n_vec++; if (out_o !== 16'(exp_seq[k])) begin n_err++; $display("FAIL rampup_out #%0d: got %0d want %0d", k, out_o, exp_seq[k]); end
        if (k == 4) begin
          n_vec++; if (state_o !== 2'(S_RUN)) begin n_err++; $display("FAIL rampup_run: got %0d want %0d", state_o, S_RUN); end
        end
        k++;
      end
    end
    valid_i = 1'b0;
    n_vec++; if (k != 5) begin n_err++; $display("FAIL rampup_count_samples: got %0d want 5", k); end
  endtask

  task automatic test_ramp_down();
    int down_seq[3] = '{3000, 1000, 0};
    int up_seq[3]   = '{2000, 4000, 5000};
    maxStep_i = 16'd2000;
    outputEnable_i = 1'b0;
    cycle();
    n_vec++; if (state_o !== 2'(S_DOWN)) begin n_err++; $display("FAIL rampdown_state: got %0d want %0d", state_o, S_DOWN); end
    for (int i = 0; i < 3; i++) begin
      send_sample(0, 0);
      n_vec++; if (out_o !== 16'(down_seq[i])) begin n_err++; $display("FAIL rampdown_out #%0d: got %0d want %0d", i, out_o, down_seq[i]); end
    end
    n_vec++; if (state_o !== 2'(S_IDLE)) begin n_err++; $display("FAIL rampdown_idle: got %0d want %0d", state_o, S_IDLE); end
    n_vec++; if (active_o !== 1'b0) begin n_err++; $display("FAIL rampdown_active: got %b want 0", active_o); end
    send_sample(0, 0);
    n_vec++; if (valid_o !== 1'b1 || out_o !== 16'sd0) begin n_err++; $display("FAIL idle_cadence: got valid %b out %0d want valid 1 out 0", valid_o, out_o); end
    outputEnable_i = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      send_sample(0, 0);
      n_vec++; if (out_o !== 16'(up_seq[i])) begin n_err++; $display("FAIL reramp_out #%0d: got %0d want %0d", i, out_o, up_seq[i]); end
    end
    outputEnable_i = 1'b0;
    cycle();
    send_sample(0, 0);
    send_sample(0, 0);
    n_vec++; if (out_o !== 16'sd1000) begin n_err++; $display("FAIL partial_down_out: got %0d want 1000", out_o); end
    outputEnable_i = 1'b1;
    cycle();
    n_vec++; if (state_o !== 2'(S_UP)) begin n_err++; $display("FAIL reenable_state: got %0d want %0d", state_o, S_UP); end
    send_sample(0, 0);
    n_vec++; if (out_o !== 16'sd3000) begin n_err++; $display("FAIL reenable_out: got %0d want 3000", out_o); end
  endtask

  task automatic test_reset_mid();
    src_v[1] = 32767;
    pack();
    send_sample(1, 100);
    maxStep_i = 16'd100;
    src_v[0] = -5000;
    pack();
    select_i = 2'd0;
    offset_i = '0;
    valid_i = 1'b1;
    cycle();
    cycle();
    n_vec++; if (satCount_o === 8'd0 || valid_o !== 1'b1) begin n_err++; $display("FAIL midramp_setup: count %0d valid %b want nonzero count and valid 1", satCount_o, valid_o); end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_vec++; if (out_o !== 16'sd0) begin n_err++; $display("FAIL async_out: got %0d want 0", out_o); end
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b want 0", valid_o); end
    n_vec++; if (satCount_o !== 8'd0) begin n_err++; $display("FAIL async_count: got %0d want 0", satCount_o); end
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++; if (state_o !== 2'(S_IDLE)) begin n_err++; $display("FAIL post_reset_state: got %0d want %0d", state_o, S_IDLE); end
    outputEnable_i = 1'b1;
    cycle();
    valid_i = 1'b1;
    cycle();
    valid_i = 1'b0;
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL latency_early: got valid %b want 0", valid_o); end
    cycle();
    n_vec++; if (valid_o !== 1'b1 || out_o !== -16'sd100) begin n_err++; $display("FAIL latency_out: got valid %b out %0d want valid 1 out -100", valid_o, out_o); end
  endtask

  task automatic test_sat_count();
    pulse_reset();
    outputEnable_i = 1'b1;
    maxStep_i = '0;
    cycle();
    src_v[0] = 32767;
    pack();
    select_i = 2'd0;
    offset_i = 16'd1;
    valid_i = 1'b1;
    for (int i = 0; i < 302; i++) cycle();
    n_vec++; if (satCount_o !== 8'd255) begin n_err++; $display("FAIL sat_hold: got %0d want 255", satCount_o); end
    satClear_i = 1'b1;
    cycle();
    satClear_i = 1'b0;
    n_vec++; if (satCount_o !== 8'd0) begin n_err++; $display("FAIL sat_clear_priority: got %0d want 0", satCount_o); end
    cycle();
    valid_i = 1'b0;
    n_vec++; if (satCount_o !== 8'd1) begin n_err++; $display("FAIL sat_after_clear: got %0d want 1", satCount_o); end
    cycle();
    cycle();
  endtask

  task automatic test_random();
    logic [BW-1:0] exp_v;
    int r;
    pulse_reset();
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 999) < 3);
      if ($urandom_range(0, 99) < 5) outputEnable_i = ~outputEnable_i;
      valid_i    = ($urandom_range(0, 99) < 70);
      satClear_i = ($urandom_range(0, 99) < 2);
      select_i   = 2'($urandom_range(0, 3));
      offset_i   = 16'($urandom_range(0, 65535));
      for (int k = 0; k < DC; k++) src_v[k] = int'($urandom_range(0, 131071)) - 65536;
      pack();
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, 3);
        case (r)
          0: maxStep_i = '0;
          1: maxStep_i = 16'($urandom_range(1, 500));
          2: maxStep_i = 16'($urandom_range(0, 65535));
          default: maxStep_i = 16'($urandom_range(1000, 20000));
        endcase
      end
      cycle();
      if (rst) exp_q.delete();
      if (m_valid) exp_q.push_back(16'(m_out));
      if (valid_o === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rnd_unexpected_valid cyc %0d: got out %0d want no sample", c, out_o);
        end else begin
          exp_v = exp_q.pop_front();
          if (out_o !== exp_v) begin n_err++; $display("FAIL rnd_sample cyc %0d: got %0d want %0d", c, out_o, $signed(exp_v)); end
        end
      end
      n_vec++; if (valid_o !== m_valid) begin n_err++; $display("FAIL rnd_valid cyc %0d: got %b want %b", c, valid_o, m_valid); end
      n_vec++; if (out_o !== 16'(m_out)) begin n_err++; $display("FAIL rnd_out cyc %0d: got %0d want %0d", c, out_o, m_out); end
      n_vec++; if (state_o !== 2'(m_state)) begin n_err++; $display("FAIL rnd_state cyc %0d: got %0d want %0d", c, state_o, m_state); end
      n_vec++; if (active_o !== (m_state != S_IDLE)) begin n_err++; $display("FAIL rnd_active cyc %0d: got %b want %b", c, active_o, m_state != S_IDLE); end
      n_vec++; if (satCount_o !== 8'(m_cnt)) begin n_err++; $display("FAIL rnd_count cyc %0d: got %0d want %0d", c, satCount_o, m_cnt); end
    end
    rst = 1'b0;
    valid_i = 1'b0;
    n_vec++; if (exp_q.size() > 1) begin n_err++; $display("FAIL rnd_leftover: got %0d queued want at most 1", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    for (int k = 0; k < DC; k++) src_v[k] = 0;
    test_reset();
    test_clip_max();
    test_clip_min();
    test_ramp_up();
    test_ramp_down();
    test_reset_mid();
    test_sat_count();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
